// File: rtl/seq_alu.sv
// Multi-cycle unsigned ALU: single-cycle add/sub, shift-add multiply and restoring
// divide, with a start/busy/done handshake toward the calculator control FSM.
module seq_alu #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result,
  output logic [WIDTH-1:0]   rem,
  output logic               carry,
  output logic               error
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {IDLE, ADDSUB, MUL, DIV, FIN} state_t;

  state_t             state;
  logic [CW-1:0]      cnt;
  logic               sub_r;
  logic [WIDTH-1:0]   a_r;
  logic [WIDTH-1:0]   b_r;
  logic [2*WIDTH-1:0] acc_r;   // product accumulator
  logic [2*WIDTH-1:0] sh_r;    // multiplicand, shifted left each step
  logic [WIDTH-1:0]   mq_r;    // multiplier (mul) or dividend -> quotient (div)
  logic [WIDTH-1:0]   pr_r;    // partial remainder

  logic [WIDTH:0]     addsub;
  logic [2*WIDTH-1:0] acc_nxt;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_trial;
  logic               div_take;

  // NOTE: every variable assigned in always_comb gets a value on every path
  // (defaults first), otherwise synthesis infers a latch.
  always_comb begin
    addsub    = sub_r ? ({1'b0, a_r} - {1'b0, b_r}) : ({1'b0, a_r} + {1'b0, b_r});
    acc_nxt   = mq_r[0] ? (acc_r + sh_r) : acc_r;
    div_shift = {pr_r, mq_r[WIDTH-1]};
    div_trial = div_shift - {1'b0, b_r};
    div_take  = (div_shift >= {1'b0, b_r});
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      sub_r  <= 1'b0;
      a_r    <= '0;
      b_r    <= '0;
      acc_r  <= '0;
      sh_r   <= '0;
      mq_r   <= '0;
      pr_r   <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      rem    <= '0;
      carry  <= 1'b0;
      error  <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            a_r   <= a;
            b_r   <= b;
            sub_r <= op[0];
            cnt   <= '0;
            acc_r <= '0;
            sh_r  <= {{WIDTH{1'b0}}, a};
            mq_r  <= op[0] ? a : b;
            pr_r  <= '0;
            busy  <= 1'b1;
            state <= op[1] ? (op[0] ? DIV : MUL) : ADDSUB;
          end
        end
        ADDSUB: begin
          result <= {{WIDTH{1'b0}}, addsub[WIDTH-1:0]};
          rem    <= '0;
          carry  <= addsub[WIDTH];
          error  <= 1'b0;
          done   <= 1'b1;
          state  <= FIN;
        end
        MUL: begin
          // WIDTH iteration cycles, then one cycle to commit the product.
          if (cnt == CW'(WIDTH)) begin
            result <= acc_r;
            rem    <= '0;
            carry  <= 1'b0;
            error  <= 1'b0;
            done   <= 1'b1;
            state  <= FIN;
          end else begin
            acc_r <= acc_nxt;
            sh_r  <= sh_r << 1;
            mq_r  <= mq_r >> 1;
            cnt   <= cnt + CW'(1);
          end
        end
        DIV: begin
          if (b_r == '0) begin
            result <= '0;
            rem    <= a_r;
            carry  <= 1'b0;
            error  <= 1'b1;
            done   <= 1'b1;
            state  <= FIN;
          end else if (cnt == CW'(WIDTH)) begin
            result <= {{WIDTH{1'b0}}, mq_r};
            rem    <= pr_r;
            carry  <= 1'b0;
            error  <= 1'b0;
            done   <= 1'b1;
            state  <= FIN;
          end else begin
            pr_r <= div_take ? div_trial[WIDTH-1:0] : div_shift[WIDTH-1:0];
            mq_r <= {mq_r[WIDTH-2:0], div_take};
            cnt  <= cnt + CW'(1);
          end
        end
        FIN: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
